// File: rtl/io_cond_pkg.sv
// Shared constants for the IO input conditioner: sync depth limits, default
// filter counter width and the controller-side channel map.
package io_cond_pkg;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int CNT_W_DEFAULT   = 8;

  localparam int CH_RESET_N = 0;
  localparam int CH_LATCH   = 1;
  localparam int CH_TRIGGER = 2;
  localparam int CH_SCLK    = 3;
  localparam int CH_MOSI    = 4;
  localparam int CH_SS_N    = 5;
endpackage

// File: rtl/io_input_channel.sv
// One conditioned input bit: pad/LA mux, polarity invert, sync chain,
// consecutive-sample glitch filter and edge pulses.
module io_input_channel #(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 8,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in,
  input  logic             la_oenb,
  input  logic             la_data_in,
  input  logic             channel_invert,
  input  logic             filter_enable,
  input  logic [CNT_W-1:0] cfg_filter_cycles,
  output logic             filtered_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             filter_busy
);
  logic                   sel;
  logic                   raw_s;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_nxt;
  logic [CNT_W:0]         cnt_inc;
  logic                   filt_nxt;

  always_comb begin
    sel      = (la_oenb ? io_in : la_data_in) ^ channel_invert;
    raw_s    = sync_q[SYNC_STAGES-1];
    // one extra bit so the increment can never wrap before the compare
    cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    filt_nxt = filtered_out;
    cnt_nxt  = '0;
    if (!filter_enable || (cfg_filter_cycles == '0)) begin
      filt_nxt = raw_s;
    end else if (raw_s != filtered_out) begin
      if (cnt_inc >= {1'b0, cfg_filter_cycles}) filt_nxt = raw_s;
      else                                      cnt_nxt  = cnt_inc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q       <= {SYNC_STAGES{RST_VAL}};
      filtered_out <= RST_VAL;
      cnt_q        <= '0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      filter_busy  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], sel};
      filtered_out <= filt_nxt;
      cnt_q        <= cnt_nxt;
      rise_pulse   <= filt_nxt & ~filtered_out;
      fall_pulse   <= ~filt_nxt & filtered_out;
      filter_busy  <= (cnt_nxt != '0);
    end
  end
endmodule

// File: rtl/io_input_conditioner.sv
// Front end for controller-side digital inputs: NUM_CHANNELS independent
// conditioned channels sharing one filter-length setting.
module io_input_conditioner
  import io_cond_pkg::*;
#(
  parameter int                      NUM_CHANNELS = 8,
  parameter int                      SYNC_STAGES  = 2,
  parameter int                      CNT_W        = CNT_W_DEFAULT,
  parameter logic [NUM_CHANNELS-1:0] RESET_VALUE  = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] io_in,
  input  logic [NUM_CHANNELS-1:0] la_oenb,
  input  logic [NUM_CHANNELS-1:0] la_data_in,
  input  logic [NUM_CHANNELS-1:0] channel_invert,
  input  logic [NUM_CHANNELS-1:0] filter_enable,
  input  logic [CNT_W-1:0]        cfg_filter_cycles,
  output logic [NUM_CHANNELS-1:0] filtered_out,
  output logic [NUM_CHANNELS-1:0] rise_pulse,
  output logic [NUM_CHANNELS-1:0] fall_pulse,
  output logic [NUM_CHANNELS-1:0] filter_busy
);
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("io_input_conditioner: SYNC_STAGES out of range");
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    io_input_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .RST_VAL     (RESET_VALUE[i])
    ) u_ch (
      .clock             (clock),
      .reset             (reset),
      .io_in             (io_in[i]),
      .la_oenb           (la_oenb[i]),
      .la_data_in        (la_data_in[i]),
      .channel_invert    (channel_invert[i]),
      .filter_enable     (filter_enable[i]),
      .cfg_filter_cycles (cfg_filter_cycles),
      .filtered_out      (filtered_out[i]),
      .rise_pulse        (rise_pulse[i]),
      .fall_pulse        (fall_pulse[i]),
      .filter_busy       (filter_busy[i])
    );
  end
endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed test-plan scenarios plus randomized traffic, all checked each cycle
// against a behavioural model of the conditioning rules.
module tb_io_input_conditioner;
  localparam int         NCH  = 8;
  localparam int         SYNC = 2;
  localparam int         CW   = 8;
  localparam logic [7:0] RV   = 8'h01;

  logic          clock = 1'b0;
  logic          reset;
  logic [NCH-1:0] io_in, la_oenb, la_data_in, channel_invert, filter_enable;
  logic [CW-1:0]  cfg_filter_cycles;
  logic [NCH-1:0] filtered_out, rise_pulse, fall_pulse, filter_busy;

  io_input_conditioner #(
    .NUM_CHANNELS (NCH),
    .SYNC_STAGES  (SYNC),
    .CNT_W        (CW),
    .RESET_VALUE  (RV)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .io_in             (io_in),
    .la_oenb           (la_oenb),
    .la_data_in        (la_data_in),
    .channel_invert    (channel_invert),
    .filter_enable     (filter_enable),
    .cfg_filter_cycles (cfg_filter_cycles),
    .filtered_out      (filtered_out),
    .rise_pulse        (rise_pulse),
    .fall_pulse        (fall_pulse),
    .filter_busy       (filter_busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a delay line of synchronised values and an integer run counter per channel.
  bit [7:0] m_pipe [SYNC];
  bit [7:0] m_filt, m_rise, m_fall, m_busy;
  int       m_cnt [NCH];

  task automatic model_edge();
    bit [7:0] sel, raw, nf;
    if (reset) begin
      for (int k = 0; k < SYNC; k++) m_pipe[k] = RV;
      m_filt = RV; m_rise = '0; m_fall = '0; m_busy = '0;
      for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
      return;
    end
    sel = ((la_oenb & io_in) | (~la_oenb & la_data_in)) ^ channel_invert;
    raw = m_pipe[SYNC-1];
    for (int k = SYNC-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = sel;
    nf = m_filt;
    for (int c = 0; c < NCH; c++) begin
      if (!filter_enable[c] || cfg_filter_cycles == 0) begin
        nf[c] = raw[c]; m_cnt[c] = 0;
      end else if (raw[c] == m_filt[c]) begin
        m_cnt[c] = 0;
      end else if (m_cnt[c] + 1 >= int'(cfg_filter_cycles)) begin
        nf[c] = raw[c]; m_cnt[c] = 0;
      end else begin
        m_cnt[c]++;
      end
      m_busy[c] = (m_cnt[c] != 0);
    end
    m_rise = nf & ~m_filt;
    m_fall = ~nf & m_filt;
    m_filt = nf;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    chk("filt", filtered_out, m_filt);
    chk("rise", rise_pulse, m_rise);
    chk("fall", fall_pulse, m_fall);
    chk("busy", filter_busy, m_busy);
    chk("excl", rise_pulse & fall_pulse, 0);
  endtask

  initial begin
    int n;
    bit seen;
    reset = 1'b1; io_in = '0; la_oenb = '1; la_data_in = '0;
    channel_invert = '0; filter_enable = '0; cfg_filter_cycles = '0;

    // reset hold with toggling pads
    for (int i = 0; i < 3; i++) begin
      io_in = ~io_in;
      tick();
      chk("rst_filt", filtered_out, 8'h01);
      chk("rst_pulse", rise_pulse | fall_pulse | filter_busy, 0);
    end
    reset = 1'b0; io_in = '0;
    repeat (5) tick();

    // bypass latency and single rise pulse
    io_in[2] = 1'b1;
    tick(); chk("byp_e1", filtered_out[2], 0);
    tick(); chk("byp_e2", filtered_out[2], 0);
    tick(); chk("byp_e3", filtered_out[2], 1); chk("byp_rise", rise_pulse[2], 1);
    tick(); chk("byp_rise_end", rise_pulse[2], 0);

    // filter: short glitch rejected, long pulse accepted at cycle 7
    cfg_filter_cycles = 8'd5; filter_enable = 8'h02;
    seen = 1'b0;
    io_in[1] = 1'b1;
    repeat (4) begin tick(); seen |= filter_busy[1]; end
    io_in[1] = 1'b0;
    repeat (8) begin tick(); seen |= filter_busy[1]; end
    chk("glitch_filt", filtered_out[1], 0);
    chk("glitch_busy", seen, 1);
    io_in[1] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!filtered_out[1] && n < 20);
    chk("flt_lat", n, 7);

    // LA override with invert, then switch back to the pad
    filter_enable = '0;
    la_oenb[0] = 1'b0; la_data_in[0] = 1'b1; io_in[0] = 1'b0; channel_invert[0] = 1'b1;
    repeat (4) tick();
    chk("ovr_filt", filtered_out[0], 0);
    la_oenb[0] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!filtered_out[0] && n < 20);
    chk("ovr_lat", n, 3);

    // lowering the threshold mid-count commits on the next differing sample
    cfg_filter_cycles = 8'd10; filter_enable[3] = 1'b1; io_in[3] = 1'b1;
    repeat (8) tick();
    chk("mid_busy", filter_busy[3], 1);
    chk("mid_hold", filtered_out[3], 0);
    cfg_filter_cycles = 8'd3;
    tick(); chk("mid_commit", filtered_out[3], 1);
    cfg_filter_cycles = 8'd10; io_in[3] = 1'b0;
    repeat (6) tick();
    chk("dis_busy", filter_busy[3], 1);
    filter_enable[3] = 1'b0;
    tick();
    chk("dis_follow", filtered_out[3], 0);
    chk("dis_busy_clr", filter_busy[3], 0);

    // reset aborts an in-progress count
    cfg_filter_cycles = 8'd5; filter_enable[4] = 1'b1; io_in[4] = 1'b1;
    repeat (5) tick();
    chk("abort_busy", filter_busy[4], 1);
    reset = 1'b1;
    tick();
    chk("abort_filt", filtered_out, 8'h01);
    chk("abort_pulse", rise_pulse | fall_pulse | filter_busy, 0);
    reset = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(3) == 0)  io_in[c]          = ~io_in[c];
        if ($urandom_range(7) == 0)  la_data_in[c]     = ~la_data_in[c];
        if ($urandom_range(31) == 0) la_oenb[c]        = ~la_oenb[c];
        if ($urandom_range(31) == 0) channel_invert[c] = ~channel_invert[c];
        if ($urandom_range(31) == 0) filter_enable[c]  = ~filter_enable[c];
      end
      if ($urandom_range(63) == 0)
        cfg_filter_cycles = ($urandom_range(7) == 0) ? CW'($urandom_range(255)) : CW'($urandom_range(6));
      reset = ($urandom_range(199) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
